imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: instruction-memory word-address width, so depth is 2^ADDR_W words.
REQ-002 SHALL have port clk, input, 1: single system clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: one-cycle pulse that begins a program load.
REQ-005 SHALL have port word_count, input, ADDR_W+1: number of 32-bit words to load; sampled on start; range 0..2^ADDR_W.
REQ-006 SHALL have port in_valid, input, 1: the byte-stream source presents a valid byte.
REQ-007 SHALL have port in_data, input, 8: program byte; each word arrives big-endian, MSB byte first.
REQ-008 SHALL have port in_ready, output, 1: the loader accepts a byte this cycle.
REQ-009 SHALL have port mem_we, output, 1: instruction-memory write strobe, one cycle per word.
REQ-010 SHALL have port mem_addr, output, ADDR_W: word address of the current write.
REQ-011 SHALL have port mem_wdata, output, 32: assembled instruction word.
REQ-012 SHALL have port cpu_hold, output, 1: holds the datapath stalled while high.
REQ-013 SHALL have port done, output, 1: load complete; stays high until the next start or reset.
REQ-014 SHALL have port error, output, 1: checksum mismatch flag.

Function
REQ-015 SHALL implement FSM states IDLE, RECV, WRITE, CHECK and DONE; CHECK exists only with the macro in REQ-031.
REQ-016 IDLE SHALL drive in_ready=0 and cpu_hold=1, and SHALL ignore in_valid.
REQ-017 In IDLE or DONE, start with word_count>0 SHALL:
- go to RECV;
- clear the byte counter, address counter, done, error and running sum;
- latch word_count into words_left;
- set cpu_hold=1.
REQ-018 start with word_count=0 SHALL go directly to CHECK (macro defined) or DONE (macro undefined).
REQ-019 start SHALL be ignored while in RECV, WRITE or CHECK.
REQ-020 RECV SHALL drive in_ready=1; a byte is accepted only when in_valid and in_ready are both high.
REQ-021 On each accepted byte, the shift register SHALL update as word = {word[23:0], in_data}.
REQ-022 Acceptance of the 4th byte SHALL move the FSM to WRITE.
REQ-023 WRITE SHALL last exactly one cycle, with:
- mem_we=1, mem_addr=addr, mem_wdata=word;
- in_ready=0.
REQ-024 After WRITE, addr SHALL increment, words_left SHALL decrement, and the running sum SHALL add word modulo 2^32.
REQ-025 From WRITE, the FSM SHALL go to RECV if words_left≠0, otherwise to CHECK or DONE.
REQ-026 Latency: mem_we SHALL assert the cycle after the 4th byte is accepted; peak throughput is 4 bytes per 5 cycles.
REQ-027 When word_count=2^ADDR_W, the last write SHALL go to address 2^ADDR_W-1; addr wrap after that write is don't-care.
REQ-028 DONE SHALL drive done=1, cpu_hold=0, in_ready=0 and mem_we=0.
REQ-029 An in_valid gap mid-word SHALL stall RECV with no loss or duplication of bytes.

Reset
REQ-030 rst=1 SHALL immediately force the FSM to IDLE and the outputs to:
- in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0;
- cpu_hold=1, done=0, error=0.
Reset mid-load discards the partial word, and no further write occurs.

Configuration
REQ-031 When IMEM_CHECKSUM_EN is defined, CHECK SHALL:
- drive in_ready=1 and accept 4 more bytes, big-endian, as the expected sum;
- set error=1 if the expected sum ≠ the running sum, else error=0;
- then go to DONE.
REQ-032 When IMEM_CHECKSUM_EN is undefined, the CHECK state and the sum logic SHALL be absent and error SHALL be tied to 0.

Verification
REQ-033 Scenario "2-word load":
- Stimulus: rst, then start with word_count=2, then bytes 20 08 00 05 8C 01 00 04 with no gaps.
- Response: mem_we pulses write 0x20080005 to addr 0 and 0x8C010004 to addr 1; done=1; cpu_hold falls to 0.
REQ-034 Scenario "gapped valid":
- Stimulus: same load as REQ-033, with in_valid low for 3 cycles after byte 2.
- Response: identical writes and data.
REQ-035 Scenario "zero-length load":
- Stimulus: start with word_count=0.
- Response: done=1 within 1 cycle (macro undefined); no mem_we.
REQ-036 Scenario "reset mid-load":
- Stimulus: rst pulse after 6 bytes of a 2-word load.
- Response: only the addr-0 write has occurred; the FSM is in IDLE with cpu_hold=1 and done=0.
REQ-037 Scenario "checksum" (IMEM_CHECKSUM_EN defined):
- Stimulus: the REQ-033 load followed by sum bytes AC 09 00 09.
- Response: error=0.
- Stimulus: the same with trailer AC 09 00 0A.
- Response: error=1, done=1.
REQ-038 Scenario "start while busy":
- Stimulus: start pulse during RECV.
- Response: the pulse is ignored; addresses continue without restarting.

Source files
------------

// File: rtl/imem_loader_if.sv
// Handshake and memory-write bundle between the byte-stream host and imem_loader.
// The loader takes the slave view; the host or bench takes the master view.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    output start, word_count, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
  );

  modport slave (
    input  start, word_count, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Loads big-endian 32-bit words from a byte stream into instruction memory, holding the CPU meanwhile.
// Optional trailing checksum check is compiled in with IMEM_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
`ifdef IMEM_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  state_t            state_reg;
  logic [1:0]        byte_cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W:0]   words_left_reg;
  logic [31:0]       word_reg;
  logic              in_ready_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [31:0]       mem_wdata_reg;
  logic              cpu_hold_reg;
  logic              done_reg;
`ifdef IMEM_CHECKSUM_EN
  logic [31:0]       sum_reg;
  logic              error_reg;
`endif

  logic        accept;
  logic [31:0] word_next;

  assign accept    = bus.in_valid & in_ready_reg;
  assign word_next = {word_reg[23:0], bus.in_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      byte_cnt_reg   <= '0;
      addr_reg       <= '0;
      words_left_reg <= '0;
      word_reg       <= '0;
      in_ready_reg   <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      cpu_hold_reg   <= 1'b1;
      done_reg       <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      sum_reg        <= '0;
      error_reg      <= 1'b0;
`endif
    end else begin
      mem_we_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            byte_cnt_reg   <= '0;
            addr_reg       <= '0;
            words_left_reg <= bus.word_count;
            done_reg       <= 1'b0;
            cpu_hold_reg   <= 1'b1;
`ifdef IMEM_CHECKSUM_EN
            sum_reg        <= '0;
            error_reg      <= 1'b0;
`endif
            if (bus.word_count != '0) begin
              state_reg    <= RECV;
              in_ready_reg <= 1'b1;
            end else begin
`ifdef IMEM_CHECKSUM_EN
              state_reg    <= CHECK;
              in_ready_reg <= 1'b1;
`else
              state_reg    <= DONE;
              done_reg     <= 1'b1;
              cpu_hold_reg <= 1'b0;
`endif
            end
          end
        end

        RECV: begin
          if (accept) begin
            word_reg     <= word_next;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            // Fourth byte: present the assembled word on the write port next cycle.
            if (byte_cnt_reg == 2'd3) begin
              state_reg     <= WRITE;
              in_ready_reg  <= 1'b0;
              mem_we_reg    <= 1'b1;
              mem_addr_reg  <= addr_reg;
              mem_wdata_reg <= word_next;
            end
          end
        end

        WRITE: begin
          addr_reg       <= addr_reg + 1'b1;
          words_left_reg <= words_left_reg - 1'b1;
`ifdef IMEM_CHECKSUM_EN
          sum_reg        <= sum_reg + word_reg;
`endif
          if (words_left_reg != (ADDR_W+1)'(1)) begin
            state_reg    <= RECV;
            in_ready_reg <= 1'b1;
          end else begin
`ifdef IMEM_CHECKSUM_EN
            state_reg    <= CHECK;
            in_ready_reg <= 1'b1;
`else
            state_reg    <= DONE;
            done_reg     <= 1'b1;
            cpu_hold_reg <= 1'b0;
`endif
          end
        end

`ifdef IMEM_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            word_reg     <= word_next;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              error_reg    <= (word_next != sum_reg);
              state_reg    <= DONE;
              in_ready_reg <= 1'b0;
              done_reg     <= 1'b1;
              cpu_hold_reg <= 1'b0;
            end
          end
        end
`endif

        default: begin
          state_reg    <= IDLE;
          in_ready_reg <= 1'b0;
          cpu_hold_reg <= 1'b1;
          done_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.cpu_hold  = cpu_hold_reg;
  assign bus.done      = done_reg;
`ifdef IMEM_CHECKSUM_EN
  assign bus.error     = error_reg;
`else
  assign bus.error     = 1'b0;
`endif

endmodule
